// File: rtl/hep_stream_if.sv
// hep_stream_if -- plaintext-in / ciphertext-out stream bundle for hep_stream.
//   in_valid/in_ready/in_data     : plaintext handshake (producer -> block)
//   out_valid/out_ready/out_ct    : ciphertext handshake (block -> consumer)
// Modports: slave = the encryption block, master = the environment driving it.
interface hep_stream_if #(
    parameter int N  = 4,
    parameter int QW = 10,
    parameter int PW = 8
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [PW-1:0]         in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [(N+1)*QW-1:0]   out_ct;

    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_ct);
    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_ct);
endinterface

// File: rtl/hep_stream.sv
// hep_stream -- streaming LWE-style encryptor.
// Each accepted plaintext m yields ciphertext (b, a_0..a_{N-1}) with a_k drawn
// from a 16-bit LFSR and b = sum(a_k*sk_k) + (m << DSH) + e  (mod 2^QW).
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   seed_load/seed : reload LFSR while idle (seed 0 maps to 16'hACE1)
//   sk             : secret key, element k at sk[(k+1)*QW-1:k*QW]
//   s (slave)      : in_valid/in_ready/in_data, out_valid/out_ready/out_ct
//   busy           : high whenever the block is not idle
// Build option: define HEP_NOISE_EN to add noise e = signed lfsr[1:0] into b;
// without it e = 0 and no noise logic exists.
module hep_stream #(
    parameter int N   = 4,
    parameter int QW  = 10,
    parameter int PW  = 8,
    parameter int DSH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            seed_load,
    input  logic [15:0]     seed,
    input  logic [N*QW-1:0] sk,
    hep_stream_if.slave     s,
    output logic            busy
);
    localparam int          KW        = (N > 1) ? $clog2(N) : 1;
    localparam logic [15:0] LFSR_INIT = 16'hACE1;

    typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, FIN = 2'd2, OUT = 2'd3} state_t;

    // x^16 + x^14 + x^13 + x^11 + 1, shifting left, feedback into bit 0
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    state_t              state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    logic [QW-1:0]       acc_q, acc_d;
    logic [PW-1:0]       m_q, m_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [(N+1)*QW-1:0] ct_q, ct_d;
    logic                out_valid_q, out_valid_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;

    logic                accept_s;
    logic [QW-1:0]       a_k_s, sk_k_s, prod_s, m_sh_s, b_s;

    assign accept_s = s.in_valid && in_ready_q && (state_q == IDLE);
    assign a_k_s    = lfsr_q[QW-1:0];
    assign sk_k_s   = sk[int'(k_q) * QW +: QW];
    // Product kept at QW bits: only the low bits survive mod 2^QW anyway
    assign prod_s   = a_k_s * sk_k_s;
    assign m_sh_s   = QW'(m_q) << DSH;

`ifdef HEP_NOISE_EN
    logic [QW-1:0] noise_s;
    // lfsr[1:0] read as 2-bit two's complement, sign-extended to QW bits
    assign noise_s = {{(QW-2){lfsr_q[1]}}, lfsr_q[1:0]};
    assign b_s     = acc_q + m_sh_s + noise_s;
`else
    assign b_s     = acc_q + m_sh_s;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_s) state_d = ACC; else state_d = IDLE;
            ACC:     if (k_q == KW'(N - 1)) state_d = FIN; else state_d = ACC;
            FIN:     state_d = OUT;
            OUT:     if (s.out_ready) state_d = IDLE; else state_d = OUT;
            default: state_d = IDLE;
        endcase
    end

    // Output flags, decoded from the next state so they register cleanly
    always_comb begin
        out_valid_d = (state_d == OUT);
        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    // Datapath: key accumulation, ciphertext assembly and LFSR stepping
    always_comb begin
        k_d    = k_q;
        acc_d  = acc_q;
        m_d    = m_q;
        lfsr_d = lfsr_q;
        ct_d   = ct_q;
        case (state_q)
            IDLE: begin
                // Seed reload wins the LFSR but does not block the transfer
                if (seed_load) begin
                    if (seed == 16'h0000) lfsr_d = LFSR_INIT;
                    else                  lfsr_d = seed;
                end else begin
                    lfsr_d = lfsr_q;
                end
                if (accept_s) begin
                    m_d   = s.in_data;
                    k_d   = '0;
                    acc_d = '0;
                end else begin
                    m_d   = m_q;
                end
            end
            ACC: begin
                ct_d[(int'(k_q) + 1) * QW +: QW] = a_k_s;
                acc_d  = acc_q + prod_s;
                lfsr_d = lfsr_step(lfsr_q);
                if (k_q == KW'(N - 1)) k_d = '0;
                else                   k_d = k_q + KW'(1);
            end
            FIN: begin
                ct_d[QW-1:0] = b_s;
                lfsr_d       = lfsr_step(lfsr_q);
            end
            OUT:     ct_d = ct_q;
            default: ct_d = ct_q;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q         <= '0;
            acc_q       <= '0;
            m_q         <= '0;
            lfsr_q      <= LFSR_INIT;
            ct_q        <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            k_q         <= k_d;
            acc_q       <= acc_d;
            m_q         <= m_d;
            lfsr_q      <= lfsr_d;
            ct_q        <= ct_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign s.in_ready  = in_ready_q;
    assign s.out_valid = out_valid_q;
    assign s.out_ct    = ct_q;
    assign busy        = busy_q;
endmodule
